// File: rtl/hazard_unit_sb_if.sv
// Control/status bundle between the 5-stage pipeline and hazard_unit_sb.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_unit_sb_if #(
    parameter int REG_AW = 5
);
    logic              CpuRst;
    logic              ICacheMiss;
    logic              DCacheMiss;
    logic              BranchE;
    logic              BranchPredictedE;
    logic              JalrE;
    logic              JalD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic [1:0]        RegReadD;
    logic              RegWriteD;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic [1:0]        RegReadE;
    logic              MemToRegE;
    logic              MduStartE;
    logic [REG_AW-1:0] RdM;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteM;
    logic              RegWriteW;

    logic              StallF, FlushF, StallD, FlushD, StallE;
    logic              FlushE, StallM, FlushM, StallW, FlushW;
    logic [1:0]        Forward1E;
    logic [1:0]        Forward2E;
    logic              MduWbEn;
    logic [REG_AW-1:0] MduWbRd;
    logic              MduBusy;

    modport master (
        output CpuRst, ICacheMiss, DCacheMiss, BranchE, BranchPredictedE, JalrE, JalD,
               Rs1D, Rs2D, RdD, RegReadD, RegWriteD, Rs1E, Rs2E, RdE, RegReadE,
               MemToRegE, MduStartE, RdM, RdW, RegWriteM, RegWriteW,
        input  StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM,
               StallW, FlushW, Forward1E, Forward2E, MduWbEn, MduWbRd, MduBusy
    );

    modport slave (
        input  CpuRst, ICacheMiss, DCacheMiss, BranchE, BranchPredictedE, JalrE, JalD,
               Rs1D, Rs2D, RdD, RegReadD, RegWriteD, Rs1E, Rs2E, RdE, RegReadE,
               MemToRegE, MduStartE, RdM, RdW, RegWriteM, RegWriteW,
        output StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM,
               StallW, FlushW, Forward1E, Forward2E, MduWbEn, MduWbRd, MduBusy
    );
endinterface

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage RV32I core: forwarding, stalls/flushes, a per-register
// scoreboard and the writeback sequencer for a single multi-cycle MUL/DIV unit.
module hazard_unit_sb #(
    parameter int REG_AW    = 5,
    parameter int MDU_LAT   = 4,
    parameter int RF_WPORTS = 1
) (
    input  logic            clk,
    input  logic            rst,
    hazard_unit_sb_if.slave hif
);
    localparam int NREG = 2 ** REG_AW;

    typedef enum logic [1:0] {IDLE, RUN, WB} mduState_t;

    mduState_t         state;
    logic [3:0]        mduCnt;
    logic [REG_AW-1:0] mduRdQ;
    logic [NREG-1:0]   sb;

    logic       useRs1D, useRs2D;
    logic       frozen, mispredict, mduStruct, loadUse, sbHit;
    logic       portConflict, wbFire, issue;
    logic [9:0] ctrl;

    always_comb begin
        useRs1D      = hif.RegReadD[1];
        useRs2D      = hif.RegReadD[0];
        frozen       = hif.ICacheMiss | hif.DCacheMiss;
        mispredict   = (hif.BranchE ^ hif.BranchPredictedE) | hif.JalrE;
        mduStruct    = hif.MduStartE & (state != IDLE);
        loadUse      = hif.MemToRegE & (hif.RdE != '0) &
                       ((useRs1D & (hif.Rs1D == hif.RdE)) | (useRs2D & (hif.Rs2D == hif.RdE)));
        sbHit        = (useRs1D & sb[hif.Rs1D]) | (useRs2D & sb[hif.Rs2D]) |
                       (hif.RegWriteD & sb[hif.RdD]);
        portConflict = (RF_WPORTS == 1) && hif.RegWriteW && (hif.RdW != '0);
        wbFire       = (state == WB) & ~frozen & ~hif.CpuRst & ~portConflict;
        issue        = (state == IDLE) & hif.MduStartE & ~hif.CpuRst & ~frozen & ~mispredict;
    end

    // Priority-ordered control rows; the bit order is {StallF,FlushF,...,StallW,FlushW}.
    always_comb begin
        ctrl = 10'b0000000000;
        if (rst || hif.CpuRst) ctrl = 10'b0101010101;
        else if (frozen)       ctrl = 10'b1010101010;
        else if (mispredict)   ctrl = 10'b0001010000;
        else if (mduStruct)    ctrl = 10'b1010100100;
        else if (loadUse)      ctrl = 10'b1010010000;
        else if (sbHit)        ctrl = 10'b1010010000;
        else if (hif.JalD)     ctrl = 10'b0001000000;
    end

    assign {hif.StallF, hif.FlushF, hif.StallD, hif.FlushD, hif.StallE,
            hif.FlushE, hif.StallM, hif.FlushM, hif.StallW, hif.FlushW} = ctrl;

    // M result takes precedence over W; x0 is never forwarded.
    always_comb begin
        hif.Forward1E = 2'b00;
        hif.Forward2E = 2'b00;
        if (!rst) begin
            if (hif.RegReadE[1] && hif.RegWriteM && hif.RdM != '0 && hif.RdM == hif.Rs1E)
                hif.Forward1E = 2'b10;
            else if (hif.RegReadE[1] && hif.RegWriteW && hif.RdW != '0 && hif.RdW == hif.Rs1E)
                hif.Forward1E = 2'b01;
            if (hif.RegReadE[0] && hif.RegWriteM && hif.RdM != '0 && hif.RdM == hif.Rs2E)
                hif.Forward2E = 2'b10;
            else if (hif.RegReadE[0] && hif.RegWriteW && hif.RdW != '0 && hif.RdW == hif.Rs2E)
                hif.Forward2E = 2'b01;
        end
    end

    assign hif.MduWbEn = wbFire & ~rst;
    assign hif.MduWbRd = mduRdQ;
    assign hif.MduBusy = (state != IDLE) & ~rst;

    // An in-flight MDU op survives mispredicts; only reset or CpuRst cancel it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mduCnt <= 4'd0;
            mduRdQ <= '0;
            sb     <= '0;
        end else if (hif.CpuRst) begin
            state  <= IDLE;
            mduCnt <= 4'd0;
            mduRdQ <= '0;
            sb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state  <= RUN;
                        mduCnt <= 4'(MDU_LAT - 1);
                        mduRdQ <= hif.RdE;
                        if (hif.RdE != '0) sb[hif.RdE] <= 1'b1;
                    end
                end
                RUN: begin
                    if (!frozen) begin
                        if (mduCnt == 4'd1) begin
                            state  <= WB;
                            mduCnt <= 4'd0;
                        end else begin
                            mduCnt <= mduCnt - 4'd1;
                        end
                    end
                end
                WB: begin
                    if (wbFire) begin
                        sb[mduRdQ] <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench for hazard_unit_sb: directed scenarios plus randomized traffic
// compared against a cycle-timestamp model of the single outstanding MDU operation.
module tb_hazard_unit_sb;
    localparam int REG_AW  = 5;
    localparam int MDU_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_unit_sb_if #(.REG_AW(REG_AW)) hif ();

    hazard_unit_sb #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .RF_WPORTS(1)) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
    );

    always #5 clk = ~clk;

    logic [9:0] ctrlObs;
    assign ctrlObs = {hif.StallF, hif.FlushF, hif.StallD, hif.FlushD, hif.StallE,
                      hif.FlushE, hif.StallM, hif.FlushM, hif.StallW, hif.FlushW};

    // Model: at most one MDU op outstanding, eligible to write back from cycle readyAt on.
    int                cyc = 0;
    bit                mBusy = 1'b0;
    logic [REG_AW-1:0] mRd = '0;
    int                mReadyAt = 0;

    function automatic bit expFrozen();
        return hif.ICacheMiss || hif.DCacheMiss;
    endfunction

    function automatic bit expMispredict();
        return (hif.BranchE != hif.BranchPredictedE) || hif.JalrE;
    endfunction

    function automatic bit expWb();
        return mBusy && (cyc >= mReadyAt) && !expFrozen() && !hif.CpuRst &&
               !(hif.RegWriteW && hif.RdW != 0);
    endfunction

    function automatic logic [9:0] expCtrl();
        bit ldUse, sbStall;
        ldUse   = hif.MemToRegE && hif.RdE != 0 &&
                  ((hif.RegReadD[1] && hif.Rs1D == hif.RdE) || (hif.RegReadD[0] && hif.Rs2D == hif.RdE));
        sbStall = mBusy && mRd != 0 &&
                  ((hif.RegReadD[1] && hif.Rs1D == mRd) || (hif.RegReadD[0] && hif.Rs2D == mRd) ||
                   (hif.RegWriteD && hif.RdD == mRd));
        if (rst || hif.CpuRst)           return 10'b0101010101;
        if (expFrozen())                 return 10'b1010101010;
        if (expMispredict())             return 10'b0001010000;
        if (hif.MduStartE && mBusy)      return 10'b1010100100;
        if (ldUse || sbStall)            return 10'b1010010000;
        if (hif.JalD)                    return 10'b0001000000;
        return 10'b0000000000;
    endfunction

    function automatic logic [1:0] expFwd(input bit used, input logic [REG_AW-1:0] rs);
        if (rst || !used || rs == 0)              return 2'b00;
        if (hif.RegWriteM && hif.RdM == rs)       return 2'b10;
        if (hif.RegWriteW && hif.RdW == rs)       return 2'b01;
        return 2'b00;
    endfunction

    task automatic updateModel();
        bit wb;
        wb = expWb();
        if (rst || hif.CpuRst) begin
            mBusy = 1'b0;
        end else if (expFrozen()) begin
            if (mBusy && cyc < mReadyAt) mReadyAt++;
        end else if (wb) begin
            mBusy = 1'b0;
        end else if (!mBusy && hif.MduStartE && !expMispredict()) begin
            mBusy    = 1'b1;
            mRd      = hif.RdE;
            mReadyAt = cyc + MDU_LAT;
        end
    endtask

    task automatic tick();
        updateModel();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clearInputs();
        hif.CpuRst = 0; hif.ICacheMiss = 0; hif.DCacheMiss = 0;
        hif.BranchE = 0; hif.BranchPredictedE = 0; hif.JalrE = 0; hif.JalD = 0;
        hif.Rs1D = 0; hif.Rs2D = 0; hif.RdD = 0; hif.RegReadD = 0; hif.RegWriteD = 0;
        hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0; hif.RegReadE = 0;
        hif.MemToRegE = 0; hif.MduStartE = 0;
        hif.RdM = 0; hif.RdW = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    endtask

    task automatic drainMdu();
        clearInputs();
        for (int i = 0; i < 32 && mBusy; i++) tick();
    endtask

    task automatic applyStimulus();
        hif.CpuRst           = ($urandom_range(99) < 2);
        hif.ICacheMiss       = ($urandom_range(99) < 6);
        hif.DCacheMiss       = ($urandom_range(99) < 6);
        hif.BranchE          = ($urandom_range(99) < 10);
        hif.BranchPredictedE = ($urandom_range(99) < 10);
        hif.JalrE            = ($urandom_range(99) < 4);
        hif.JalD             = ($urandom_range(99) < 10);
        hif.Rs1D = 5'($urandom_range(7)); hif.Rs2D = 5'($urandom_range(7));
        hif.RdD  = 5'($urandom_range(7)); hif.RegReadD = 2'($urandom_range(3));
        hif.RegWriteD = 1'($urandom_range(1));
        hif.Rs1E = 5'($urandom_range(7)); hif.Rs2E = 5'($urandom_range(7));
        hif.RdE  = 5'($urandom_range(7)); hif.RegReadE = 2'($urandom_range(3));
        hif.MemToRegE = ($urandom_range(99) < 20);
        hif.MduStartE = ($urandom_range(99) < 25);
        hif.RdM = 5'($urandom_range(7)); hif.RdW = 5'($urandom_range(7));
        hif.RegWriteM = 1'($urandom_range(1));
        hif.RegWriteW = ($urandom_range(99) < 30);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        mBusy = 1'b0;
        #1;
        checks++;
        if (ctrlObs !== 10'b0101010101) begin
            failures++; $display("[TB] FAIL reset_ctrl got=%b want=0101010101", ctrlObs);
        end
        checks++;
        if (hif.MduBusy !== 1'b0 || hif.MduWbEn !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_mdu busy=%b wb=%b want 0/0", hif.MduBusy, hif.MduWbEn);
        end
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctrlObs !== 10'b0 || hif.MduBusy !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_release ctrl=%b busy=%b want 0/0", ctrlObs, hif.MduBusy);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit sawWb;
        drainMdu();
        hif.MduStartE = 1; hif.RdE = 5'd12;
        tick();
        clearInputs();
        tick();
        rst = 1'b1;
        hif.RegReadE = 2'b11; hif.Rs1E = 5'd4; hif.RegWriteM = 1; hif.RdM = 5'd4;
        hif.Rs1D = 5'd12; hif.RegReadD = 2'b10;
        #1;
        checks++;
        if (ctrlObs !== 10'b0101010101 || hif.Forward1E !== 2'b00 || hif.MduBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_run ctrl=%b fwd1=%b busy=%b want 0101010101/00/0",
                     ctrlObs, hif.Forward1E, hif.MduBusy);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctrlObs !== 10'b0 || hif.MduBusy !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_mid_run_release ctrl=%b busy=%b want 0/0", ctrlObs, hif.MduBusy);
        end
        sawWb = 0;
        for (int i = 0; i < 6; i++) begin
            if (hif.MduWbEn === 1'b1) sawWb = 1;
            tick();
        end
        checks++;
        if (sawWb) begin
            failures++; $display("[TB] FAIL rst_mid_run_wb got MduWbEn=1 want never");
        end
        clearInputs();
    endtask

    task automatic test_mdu_stall();
        drainMdu();
        hif.MduStartE = 1; hif.RdE = 5'd5;
        #1;
        checks++;
        if (ctrlObs !== 10'b0 || hif.MduBusy !== 1'b0) begin
            failures++; $display("[TB] FAIL mul_issue ctrl=%b busy=%b want 0/0", ctrlObs, hif.MduBusy);
        end
        tick();
        clearInputs();
        hif.Rs1D = 5'd5; hif.Rs2D = 5'd1; hif.RegReadD = 2'b11; hif.RegWriteD = 1; hif.RdD = 5'd6;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (ctrlObs !== 10'b1010010000) begin
                failures++; $display("[TB] FAIL add_stall t+%0d ctrl=%b want 1010010000", k, ctrlObs);
            end
            checks++;
            if (hif.MduWbEn !== (k == 4)) begin
                failures++; $display("[TB] FAIL mul_wb_en t+%0d got=%b want=%b", k, hif.MduWbEn, (k == 4));
            end
            if (k == 4) begin
                checks++;
                if (hif.MduWbRd !== 5'd5) begin
                    failures++; $display("[TB] FAIL mul_wb_rd got=%0d want=5", hif.MduWbRd);
                end
            end
            tick();
        end
        checks++;
        if (ctrlObs !== 10'b0 || hif.MduBusy !== 1'b0) begin
            failures++; $display("[TB] FAIL add_leave ctrl=%b busy=%b want 0/0", ctrlObs, hif.MduBusy);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_port_conflict();
        drainMdu();
        hif.MduStartE = 1; hif.RdE = 5'd9;
        tick();
        clearInputs();
        tick(); tick(); tick();
        hif.RegWriteW = 1; hif.RdW = 5'd7; hif.Rs1D = 5'd9; hif.RegReadD = 2'b10;
        #1;
        checks++;
        if (hif.MduWbEn !== 1'b0 || ctrlObs !== 10'b1010010000) begin
            failures++; $display("[TB] FAIL port_conflict wb=%b ctrl=%b want 0/1010010000", hif.MduWbEn, ctrlObs);
        end
        tick();
        hif.RegWriteW = 0; hif.RdW = 0;
        #1;
        checks++;
        if (hif.MduWbEn !== 1'b1 || hif.MduWbRd !== 5'd9) begin
            failures++; $display("[TB] FAIL port_conflict_retry wb=%b rd=%0d want 1/9", hif.MduWbEn, hif.MduWbRd);
        end
        tick();
        checks++;
        if (ctrlObs !== 10'b0 || hif.MduBusy !== 1'b0) begin
            failures++; $display("[TB] FAIL port_conflict_done ctrl=%b busy=%b want 0/0", ctrlObs, hif.MduBusy);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_freeze();
        int wbCycle;
        drainMdu();
        hif.MduStartE = 1; hif.RdE = 5'd8;
        tick();
        clearInputs();
        hif.DCacheMiss = 1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++;
            if (ctrlObs !== 10'b1010101010 || hif.MduWbEn !== 1'b0) begin
                failures++; $display("[TB] FAIL freeze t+%0d ctrl=%b wb=%b want 1010101010/0", k, ctrlObs, hif.MduWbEn);
            end
            tick();
        end
        hif.DCacheMiss = 0;
        wbCycle = -1;
        for (int k = 4; k <= 10 && wbCycle < 0; k++) begin
            #1;
            if (hif.MduWbEn === 1'b1) wbCycle = k;
            tick();
        end
        checks++;
        if (wbCycle != 7) begin
            failures++; $display("[TB] FAIL freeze_delay wb at t+%0d want t+7", wbCycle);
        end
        clearInputs();
    endtask

    task automatic test_priority_forward();
        drainMdu();
        hif.BranchE = 1; hif.BranchPredictedE = 0;
        hif.MemToRegE = 1; hif.RdE = 5'd3; hif.Rs1D = 5'd3; hif.RegReadD = 2'b10;
        hif.RegReadE = 2'b10; hif.Rs1E = 5'd3; hif.Rs2E = 5'd3;
        hif.RegWriteM = 1; hif.RdM = 5'd3; hif.RegWriteW = 1; hif.RdW = 5'd3;
        #1;
        checks++;
        if (ctrlObs !== 10'b0001010000) begin
            failures++; $display("[TB] FAIL mispredict_wins ctrl=%b want 0001010000", ctrlObs);
        end
        checks++;
        if (hif.Forward1E !== 2'b10 || hif.Forward2E !== 2'b00) begin
            failures++; $display("[TB] FAIL fwd_m_wins f1=%b f2=%b want 10/00", hif.Forward1E, hif.Forward2E);
        end
        hif.BranchE = 0;
        #1;
        checks++;
        if (ctrlObs !== 10'b1010010000) begin
            failures++; $display("[TB] FAIL load_use ctrl=%b want 1010010000", ctrlObs);
        end
        hif.RegWriteM = 0; hif.RegReadE = 2'b11;
        #1;
        checks++;
        if (hif.Forward1E !== 2'b01 || hif.Forward2E !== 2'b01) begin
            failures++; $display("[TB] FAIL fwd_w f1=%b f2=%b want 01/01", hif.Forward1E, hif.Forward2E);
        end
        hif.RdW = 0; hif.Rs1E = 0; hif.RegWriteM = 1; hif.RdM = 0;
        hif.MemToRegE = 0; hif.JalD = 1;
        #1;
        checks++;
        if (hif.Forward1E !== 2'b00 || ctrlObs !== 10'b0001000000) begin
            failures++; $display("[TB] FAIL x0_jal f1=%b ctrl=%b want 00/0001000000", hif.Forward1E, ctrlObs);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_back_to_back();
        bit sawWb;
        drainMdu();
        hif.MduStartE = 1; hif.RdE = 5'd10;
        tick();
        hif.RdE = 5'd11;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (ctrlObs !== 10'b1010100100) begin
                failures++; $display("[TB] FAIL mdu_struct t+%0d ctrl=%b want 1010100100", k, ctrlObs);
            end
            tick();
        end
        #1;
        checks++;
        if (ctrlObs !== 10'b0 || hif.MduBusy !== 1'b0) begin
            failures++; $display("[TB] FAIL second_issue ctrl=%b busy=%b want 0/0", ctrlObs, hif.MduBusy);
        end
        tick();
        clearInputs();
        #1;
        checks++;
        if (hif.MduBusy !== 1'b1) begin
            failures++; $display("[TB] FAIL second_busy got=%b want 1", hif.MduBusy);
        end
        tick();
        hif.CpuRst = 1;
        #1;
        checks++;
        if (ctrlObs !== 10'b0101010101) begin
            failures++; $display("[TB] FAIL cpurst_flush ctrl=%b want 0101010101", ctrlObs);
        end
        tick();
        hif.CpuRst = 0; hif.Rs1D = 5'd11; hif.RegReadD = 2'b10;
        #1;
        checks++;
        if (hif.MduBusy !== 1'b0 || ctrlObs !== 10'b0) begin
            failures++; $display("[TB] FAIL cpurst_idle busy=%b ctrl=%b want 0/0", hif.MduBusy, ctrlObs);
        end
        sawWb = 0;
        for (int i = 0; i < 5; i++) begin
            if (hif.MduWbEn === 1'b1) sawWb = 1;
            tick();
            #1;
        end
        checks++;
        if (sawWb) begin
            failures++; $display("[TB] FAIL cpurst_cancel got MduWbEn=1 want never");
        end
        clearInputs();
    endtask

    task automatic test_random();
        logic [9:0] eCtrl;
        logic [1:0] eF1, eF2;
        bit         eWb;
        int         bad;
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            applyStimulus();
            #1;
            eCtrl = expCtrl();
            eF1   = expFwd(hif.RegReadE[1], hif.Rs1E);
            eF2   = expFwd(hif.RegReadE[0], hif.Rs2E);
            eWb   = expWb();
            checks++;
            if (ctrlObs !== eCtrl || hif.Forward1E !== eF1 || hif.Forward2E !== eF2 ||
                hif.MduWbEn !== eWb || hif.MduBusy !== mBusy ||
                (eWb && hif.MduWbRd !== mRd)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("[TB] FAIL random cyc=%0d ctrl=%b/%b f1=%b/%b f2=%b/%b wb=%b/%b busy=%b/%b rd=%0d/%0d (got/want)",
                             cyc, ctrlObs, eCtrl, hif.Forward1E, eF1, hif.Forward2E, eF2,
                             hif.MduWbEn, eWb, hif.MduBusy, mBusy, hif.MduWbRd, mRd);
            end
            tick();
        end
        clearInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearInputs();
        test_reset();
        test_mdu_stall();
        test_port_conflict();
        test_freeze();
        test_priority_forward();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
